// File: rtl/axi_r_pkg.sv
// rtl/axi_r_pkg.sv - shared types, widths and routing tags for the R-channel interconnect.
package axi_r_pkg;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_RESP_BITS = 2;
  localparam int NUM_S         = 3;

  localparam logic [3:0] TAG_M0 = 4'h0;
  localparam logic [3:0] TAG_M1 = 4'h1;

  typedef enum logic {IDLE, BUSY} r_state_e;
  typedef logic [1:0] slv_sel_t;
  typedef enum logic [1:0] {DEST_M0, DEST_M1, DEST_NONE} dest_e;

  // Slave index successor with S2 -> S0 wrap.
  function automatic slv_sel_t next_slv(input slv_sel_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction
endpackage

// File: rtl/r_arbiter.sv
// rtl/r_arbiter.sv - 3-way slave request arbiter; round-robin from rr_ptr when R_CH_RR_EN
// is defined, fixed priority S0 > S1 > S2 otherwise.
module r_arbiter
  import axi_r_pkg::*;
(
  input  logic [NUM_S-1:0] req_i,
`ifdef R_CH_RR_EN
  input  slv_sel_t         rr_ptr_i,
`endif
  output slv_sel_t         grant_o,
  output logic             any_req_o
);

`ifdef R_CH_RR_EN
  slv_sel_t cand;
  logic     found;

  always_comb begin
    grant_o   = 2'd0;
    any_req_o = |req_i;
    found     = 1'b0;
    cand      = rr_ptr_i;
    for (int i = 0; i < NUM_S; i++) begin
      if (!found && req_i[cand]) begin
        grant_o = cand;
        found   = 1'b1;
      end
      cand = next_slv(cand);
    end
  end
`else
  always_comb begin
    grant_o   = 2'd0;
    any_req_o = |req_i;
    if (req_i[0])      grant_o = 2'd0;
    else if (req_i[1]) grant_o = 2'd1;
    else if (req_i[2]) grant_o = 2'd2;
  end
`endif

endmodule

// File: rtl/r_ch.sv
// rtl/r_ch.sv - AXI read-data channel: locks one slave per burst and routes beats to M0/M1
// by ID tag. Macro R_CH_RR_EN selects round-robin arbitration (fixed priority otherwise).
module r_ch
  import axi_r_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  output logic [AXI_ID_BITS-1:0]   id_m0_o,
  output logic [AXI_DATA_BITS-1:0] data_m0_o,
  output logic [AXI_RESP_BITS-1:0] resp_m0_o,
  output logic                     last_m0_o,
  output logic                     valid_m0_o,
  input  logic                     ready_m0_i,
  output logic [AXI_ID_BITS-1:0]   id_m1_o,
  output logic [AXI_DATA_BITS-1:0] data_m1_o,
  output logic [AXI_RESP_BITS-1:0] resp_m1_o,
  output logic                     last_m1_o,
  output logic                     valid_m1_o,
  input  logic                     ready_m1_i,
  input  logic [AXI_IDS_BITS-1:0]  id_s0_i,
  input  logic [AXI_DATA_BITS-1:0] data_s0_i,
  input  logic [AXI_RESP_BITS-1:0] resp_s0_i,
  input  logic                     last_s0_i,
  input  logic                     valid_s0_i,
  output logic                     ready_s0_o,
  input  logic [AXI_IDS_BITS-1:0]  id_s1_i,
  input  logic [AXI_DATA_BITS-1:0] data_s1_i,
  input  logic [AXI_RESP_BITS-1:0] resp_s1_i,
  input  logic                     last_s1_i,
  input  logic                     valid_s1_i,
  output logic                     ready_s1_o,
  input  logic [AXI_IDS_BITS-1:0]  id_s2_i,
  input  logic [AXI_DATA_BITS-1:0] data_s2_i,
  input  logic [AXI_RESP_BITS-1:0] resp_s2_i,
  input  logic                     last_s2_i,
  input  logic                     valid_s2_i,
  output logic                     ready_s2_o
);

  r_state_e state_q, state_d;
  slv_sel_t grant_q, grant_d;
  slv_sel_t win;
  logic     any_req;

  logic [AXI_IDS_BITS-1:0]  id_s   [NUM_S];
  logic [AXI_DATA_BITS-1:0] data_s [NUM_S];
  logic [AXI_RESP_BITS-1:0] resp_s [NUM_S];
  logic [NUM_S-1:0]         last_s, valid_s;

  assign id_s    = '{id_s0_i, id_s1_i, id_s2_i};
  assign data_s  = '{data_s0_i, data_s1_i, data_s2_i};
  assign resp_s  = '{resp_s0_i, resp_s1_i, resp_s2_i};
  assign last_s  = {last_s2_i, last_s1_i, last_s0_i};
  assign valid_s = {valid_s2_i, valid_s1_i, valid_s0_i};

  logic [AXI_IDS_BITS-1:0]  g_id;
  logic [AXI_DATA_BITS-1:0] g_data;
  logic [AXI_RESP_BITS-1:0] g_resp;
  logic                     g_last, g_valid, g_ready;
  dest_e                    dest;

  assign g_id    = id_s[grant_q];
  assign g_data  = data_s[grant_q];
  assign g_resp  = resp_s[grant_q];
  assign g_last  = last_s[grant_q];
  assign g_valid = valid_s[grant_q];

  always_comb begin
    if (g_id[7:4] == TAG_M0)      dest = DEST_M0;
    else if (g_id[7:4] == TAG_M1) dest = DEST_M1;
    else                          dest = DEST_NONE;
  end

`ifdef R_CH_RR_EN
  slv_sel_t rr_ptr_q, rr_ptr_d;

  r_arbiter u_arb (
    .req_i     (valid_s),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (win),
    .any_req_o (any_req)
  );
`else
  r_arbiter u_arb (
    .req_i     (valid_s),
    .grant_o   (win),
    .any_req_o (any_req)
  );
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
`ifdef R_CH_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    g_ready    = 1'b0;
    id_m0_o    = '0;
    data_m0_o  = '0;
    resp_m0_o  = '0;
    last_m0_o  = 1'b0;
    valid_m0_o = 1'b0;
    id_m1_o    = '0;
    data_m1_o  = '0;
    resp_m1_o  = '0;
    last_m1_o  = 1'b0;
    valid_m1_o = 1'b0;
    ready_s0_o = 1'b0;
    ready_s1_o = 1'b0;
    ready_s2_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
          state_d = BUSY;
        end
      end
      BUSY: begin
        unique case (dest)
          DEST_M0: begin
            valid_m0_o = g_valid;
            id_m0_o    = g_id[AXI_ID_BITS-1:0];
            data_m0_o  = g_data;
            resp_m0_o  = g_resp;
            last_m0_o  = g_last;
            g_ready    = ready_m0_i;
          end
          DEST_M1: begin
            valid_m1_o = g_valid;
            id_m1_o    = g_id[AXI_ID_BITS-1:0];
            data_m1_o  = g_data;
            resp_m1_o  = g_resp;
            last_m1_o  = g_last;
            g_ready    = ready_m1_i;
          end
          default: g_ready = 1'b1; // unroutable tag: drain and drop
        endcase
        unique case (grant_q)
          2'd0:    ready_s0_o = g_ready;
          2'd1:    ready_s1_o = g_ready;
          default: ready_s2_o = g_ready;
        endcase
        if (g_valid && g_ready && g_last) begin
          state_d  = IDLE;
`ifdef R_CH_RR_EN
          rr_ptr_d = next_slv(grant_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
`ifdef R_CH_RR_EN
      rr_ptr_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
`ifdef R_CH_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_r_ch.sv
// tb/tb_r_ch.sv - self-checking bench for r_ch with slave drivers and per-master scoreboards.
`timescale 1ns/1ps
module tb_r_ch;
  import axi_r_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  id_m   [2];
  logic [31:0] data_m [2];
  logic [1:0]  resp_m [2];
  logic        last_m [2];
  logic        valid_m[2];
  logic        ready_m[2];
  logic [7:0]  id_s   [3];
  logic [31:0] data_s [3];
  logic [1:0]  resp_s [3];
  logic        last_s [3];
  logic        valid_s[3];
  logic        ready_s[3];
  logic        gap    [3];

  r_ch dut (
    .clk(clk), .rst(rst),
    .id_m0_o(id_m[0]), .data_m0_o(data_m[0]), .resp_m0_o(resp_m[0]),
    .last_m0_o(last_m[0]), .valid_m0_o(valid_m[0]), .ready_m0_i(ready_m[0]),
    .id_m1_o(id_m[1]), .data_m1_o(data_m[1]), .resp_m1_o(resp_m[1]),
    .last_m1_o(last_m[1]), .valid_m1_o(valid_m[1]), .ready_m1_i(ready_m[1]),
    .id_s0_i(id_s[0]), .data_s0_i(data_s[0]), .resp_s0_i(resp_s[0]),
    .last_s0_i(last_s[0]), .valid_s0_i(valid_s[0]), .ready_s0_o(ready_s[0]),
    .id_s1_i(id_s[1]), .data_s1_i(data_s[1]), .resp_s1_i(resp_s[1]),
    .last_s1_i(last_s[1]), .valid_s1_i(valid_s[1]), .ready_s1_o(ready_s[1]),
    .id_s2_i(id_s[2]), .data_s2_i(data_s[2]), .resp_s2_i(resp_s[2]),
    .last_s2_i(last_s[2]), .valid_s2_i(valid_s[2]), .ready_s2_o(ready_s[2])
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    int         s;
    logic [7:0] id;
    int         n;
    int         dest;
  } vec_t;

  beat_t sq [3][$];
  beat_t exq[2][$];
  int    sbids[3][$];
  logic [7:0] bid_id[256];
  int    bid_n [256];
  int    bid_s [256];
  int    next_bid = 1;
  int    order_q[$];
  int    rr_model = 0;
  int    acc[2];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int s, input int bid, input int k, input int n,
                                    input logic [7:0] id);
    beat_t b;
    b.id   = id;
    b.data = {4'hA, 4'(s), 8'(bid), 8'(k), 8'(k * 17 + bid)};
    b.resp = 2'(k + s);
    b.last = (k == n - 1);
    return b;
  endfunction

  task automatic push_burst(input int s, input logic [7:0] id, input int n);
    int bid;
    bid = next_bid++;
    bid_id[bid] = id;
    bid_n[bid]  = n;
    bid_s[bid]  = s;
    sbids[s].push_back(bid);
    for (int k = 0; k < n; k++) sq[s].push_back(mk_beat(s, bid, k, n, id));
  endtask

  task automatic push_exp(input int bid, input int dest);
    if (dest < 2)
      for (int k = 0; k < bid_n[bid]; k++)
        exq[dest].push_back(mk_beat(bid_s[bid], bid, k, bid_n[bid], bid_id[bid]));
  endtask

  // Expected grant sequence when all pending bursts are already requesting.
  task automatic arb_model(input int p0, input int p1, input int p2);
    int pend[3];
    int w;
    pend = '{p0, p1, p2};
    order_q.delete();
    while (pend[0] + pend[1] + pend[2] > 0) begin
      w = -1;
`ifdef R_CH_RR_EN
      for (int i = 0; i < 3; i++) if (w < 0 && pend[(rr_model + i) % 3] > 0) w = (rr_model + i) % 3;
`else
      for (int i = 0; i < 3; i++) if (w < 0 && pend[i] > 0) w = i;
`endif
      order_q.push_back(w);
      pend[w]--;
      rr_model = (w + 1) % 3;
    end
  endtask

  task automatic push_ordered(input int d0, input int d1, input int d2);
    int dst[3];
    dst = '{d0, d1, d2};
    foreach (order_q[i]) push_exp(sbids[order_q[i]].pop_front(), dst[order_q[i]]);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit busy();
    return (sq[0].size() + sq[1].size() + sq[2].size() + exq[0].size() + exq[1].size()) != 0;
  endfunction

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_complete"}, busy(), 0);
  endtask

  task automatic chk_idle(input string nm);
    @(negedge clk);
    chk(nm, {valid_m[0], valid_m[1], ready_s[0], ready_s[1], ready_s[2]}, 5'b0);
  endtask

  // Slave drivers: retire a beat after a seen handshake, then present the queue head.
  initial begin
    bit hs[3];
    beat_t b;
    for (int s = 0; s < 3; s++) begin
      valid_s[s] = 1'b0; id_s[s] = '0; data_s[s] = '0; resp_s[s] = '0; last_s[s] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) hs[s] = valid_s[s] && ready_s[s] && rst;
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        if (hs[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        if (sq[s].size() > 0 && !gap[s]) begin
          b = sq[s][0];
          id_s[s] = b.id; data_s[s] = b.data; resp_s[s] = b.resp; last_s[s] = b.last;
          valid_s[s] = 1'b1;
        end else begin
          valid_s[s] = 1'b0;
        end
      end
    end
  end

  // Master-side scoreboard: every valid must be expected, every accepted beat must match.
  logic [38:0] hold_v[2];
  logic        stalled[2];
  initial begin
    beat_t e;
    logic [38:0] cur;
    stalled = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        cur = {id_m[m], data_m[m], resp_m[m], last_m[m]};
        if (rst && valid_m[m]) begin
          if (stalled[m]) chk($sformatf("m%0d_stall_stable", m), 64'(cur), 64'(hold_v[m]));
          chk($sformatf("m%0d_no_stray_valid", m), exq[m].size() != 0, 1);
          if (ready_m[m] && exq[m].size() != 0) begin
            e = exq[m].pop_front();
            chk($sformatf("m%0d_beat", m), 64'(cur), 64'({e.id[3:0], e.data, e.resp, e.last}));
            acc[m]++;
          end
        end
        stalled[m] = rst && valid_m[m] && !ready_m[m];
        hold_v[m]  = cur;
      end
    end
  end

  initial begin
    vec_t vt[6];
    int a0, a1, n;
    logic pat[4];
    vt[0] = '{1, 8'h13, 4, 1};
    vt[1] = '{0, 8'h75, 3, 2};
    vt[2] = '{2, 8'h0A, 2, 0};
    vt[3] = '{0, 8'h1F, 1, 1};
    vt[4] = '{1, 8'h05, 3, 0};
    vt[5] = '{2, 8'h2C, 2, 2};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    acc   = '{0, 0};
    gap   = '{1'b0, 1'b0, 1'b0};
    ready_m = '{1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #2;
    chk("reset_handshakes", {valid_m[0], valid_m[1], ready_s[0], ready_s[1], ready_s[2]}, 5'b0);
    chk("reset_payload", {id_m[0], data_m[0], resp_m[0], last_m[0], id_m[1], data_m[1]}, 64'b0);
    rst = 1'b1;
    tick();

    // Single S1 burst: one bubble cycle, then beats on M1 with the 4-bit ID.
    push_burst(1, 8'h13, 4);
    push_exp(sbids[1].pop_front(), 1);
    n = 0;
    while (!valid_s[1] && n < 10) begin tick(); n++; end
    @(negedge clk);
    chk("bubble_no_valid", {valid_m[0], valid_m[1], ready_s[1]}, 3'b0);
    tick();
    @(negedge clk);
    chk("first_beat_m1", {valid_m[1], id_m[1], valid_m[0]}, {1'b1, 4'h3, 1'b0});
    wait_done(20, "single_s1");
    chk_idle("single_s1_idle");
    rr_model = 2;

    // Table of isolated bursts covering every slave and every routing outcome.
    for (int i = 0; i < 6; i++) begin
      a0 = acc[0];
      a1 = acc[1];
      push_burst(vt[i].s, vt[i].id, vt[i].n);
      push_exp(sbids[vt[i].s].pop_front(), vt[i].dest);
      wait_done(vt[i].n + 4, $sformatf("vec%0d", i));
      chk_idle($sformatf("vec%0d_idle", i));
      chk($sformatf("vec%0d_m0_beats", i), acc[0] - a0, (vt[i].dest == 0) ? vt[i].n : 0);
      chk($sformatf("vec%0d_m1_beats", i), acc[1] - a1, (vt[i].dest == 1) ? vt[i].n : 0);
      rr_model = (vt[i].s + 1) % 3;
    end

    // Three-way contention, all to M0; grant order shows in the M0 beat order.
    push_burst(0, 8'h01, 2);
    push_burst(1, 8'h02, 2);
    push_burst(2, 8'h03, 2);
    arb_model(1, 1, 1);
    push_ordered(0, 0, 0);
    wait_done(40, "contention");
    chk_idle("contention_idle");

    // S0 re-requests back-to-back while S1 waits.
    push_burst(0, 8'h04, 2);
    push_burst(0, 8'h05, 2);
    push_burst(1, 8'h06, 2);
    arb_model(2, 1, 0);
    push_ordered(0, 0, 0);
    wait_done(40, "rerequest");
    chk_idle("rerequest_idle");

    // Backpressure on M0 during an S2 burst.
    push_burst(2, 8'h07, 4);
    push_exp(sbids[2].pop_front(), 0);
    n = 0;
    while (!valid_m[0] && n < 10) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      ready_m[0] = pat[k];
      @(negedge clk);
      chk($sformatf("bp_ready_mirror%0d", k), ready_s[2], ready_m[0]);
      tick();
    end
    ready_m[0] = 1'b1;
    wait_done(20, "backpressure");
    chk_idle("backpressure_idle");
    rr_model = 0;

    // Interleaved destinations with a mid-burst valid gap on S0.
    push_burst(0, 8'h1A, 3);
    push_burst(1, 8'h02, 3);
    arb_model(1, 1, 0);
    push_ordered(1, 0, 0);
    tick(); tick(); tick();
    gap[0] = 1'b1;
    tick();
    gap[0] = 1'b0;
    wait_done(30, "interleave");
    chk_idle("interleave_idle");

    // Reset during beat 2 of a 4-beat burst.
    a0 = acc[0];
    push_burst(1, 8'h04, 4);
    push_exp(sbids[1].pop_front(), 0);
    n = 0;
    while (acc[0] == a0 && n < 12) begin tick(); n++; end
    chk("mid_reset_beat1_seen", acc[0] - a0, 1);
    rst = 1'b0;
    #1;
    chk("mid_reset_async", {valid_m[0], ready_s[1], data_m[0]}, 34'b0);
    for (int s = 0; s < 3; s++) begin sq[s].delete(); sbids[s].delete(); end
    exq[0].delete();
    exq[1].delete();
    tick(); tick();
    rst = 1'b1;
    rr_model = 0;
    tick();
    push_burst(2, 8'h08, 2);
    push_burst(1, 8'h09, 2);
    arb_model(0, 1, 1);
    push_ordered(0, 0, 0);
    wait_done(30, "post_reset");
    chk_idle("post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
